// File: rtl/cordic_pkg.sv
// -----------------------------------------------------------------------------
// cordic_pkg
// Shared definitions for the CORDIC sine/cosine sequencing logic:
//   - cordic_state_e : 3-bit state encoding of the sequencing FSM
//   - OP_*           : operation select codes (cosine / sine)
//   - REG_*          : quadrant codes delivered by range reduction
//   - needs_invert() : final sign correction rule for an op/quadrant pair
// -----------------------------------------------------------------------------
package cordic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_IN   = 3'd1,
    ST_INIT      = 3'd2,
    ST_START_ADD = 3'd3,
    ST_WAIT_ADD  = 3'd4,
    ST_UPDATE    = 3'd5,
    ST_SIGN_FIX  = 3'd6,
    ST_DONE      = 3'd7
  } cordic_state_e;

  localparam logic OP_COS = 1'b0;
  localparam logic OP_SIN = 1'b1;

  localparam logic [1:0] REG_NONE0   = 2'b00;
  localparam logic [1:0] REG_INV_COS = 2'b01;
  localparam logic [1:0] REG_INV_SIN = 2'b10;
  localparam logic [1:0] REG_NONE3   = 2'b11;

  // Only two quadrant/operation pairs flip the sign of the final result;
  // codes 00 and 11 never do.
  function automatic logic needs_invert(input logic op, input logic [1:0] region);
    return ((op == OP_COS) && (region == REG_INV_COS)) ||
           ((op == OP_SIN) && (region == REG_INV_SIN));
  endfunction

endpackage

// File: rtl/cordic_iter_counter.sv
// -----------------------------------------------------------------------------
// cordic_iter_counter
// Loadable up-counter with synchronous clear, count enable and a terminal
// flag. The count saturates at LAST instead of wrapping, so it never exceeds
// LAST.
// Ports:
//   clk      in  clock, rising edge
//   rst      in  asynchronous active-low reset (count -> 0)
//   clr      in  synchronous clear (highest priority)
//   load     in  synchronous load of load_val
//   load_val in  value captured when load=1
//   en       in  count enable (ignored once term=1)
//   count    out current count
//   term     out count == LAST
// -----------------------------------------------------------------------------
module cordic_iter_counter #(
  parameter int W    = 5,
  parameter int LAST = 23
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         term
);

  logic [W-1:0] count_reg;

  assign term  = (count_reg == W'(LAST));
  assign count = count_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (en && !term) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/cordic_seq_ctrl.sv
// -----------------------------------------------------------------------------
// cordic_seq_ctrl
// Sequencing FSM for the CORDIC sine/cosine datapath. On a start request it
// latches the operation and quadrant, loads the input registers, initialises
// the iteration registers, then runs ITER micro-rotations, each one a
// handshake with the floating-point add/sub unit. A stalled add/sub is
// abandoned after TMO cycles and flagged. Finally the sign-corrected result is
// captured and offered with a ready/ack handshake.
// Ports:
//   clk               in  clock, rising edge
//   rst               in  asynchronous active-low reset
//   beg_fsm_cordic    in  start request (IDLE only)
//   ack_cordic        in  consumer acknowledge (DONE only)
//   operation         in  0 = cosine, 1 = sine
//   shift_region_flag in  quadrant code from range reduction
//   add_sub_ready     in  FP add/sub result valid (WAIT_ADD only)
//   busy              out high in every state except IDLE
//   load_inputs       out pulse: capture angle into input registers
//   sel_mux_init      out 1 = iteration regs take initial values
//   load_regs_iter    out pulse: capture X/Y/Z iteration results
//   enab_add_sub      out pulse: start FP add/sub
//   iter_count        out current micro-rotation index
//   invert_sign       out final sign-inverter control
//   load_result       out pulse: capture sign-corrected result
//   ready_cordic      out result valid, held until ack
//   err_timeout       out add/sub stalled; valid with ready_cordic
// All outputs are decoded from registered state only.
// -----------------------------------------------------------------------------
module cordic_seq_ctrl
  import cordic_pkg::*;
#(
  parameter int ITER  = 24,
  parameter int CNT_W = 5,
  parameter int TMO   = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             beg_fsm_cordic,
  input  logic             ack_cordic,
  input  logic             operation,
  input  logic [1:0]       shift_region_flag,
  input  logic             add_sub_ready,
  output logic             busy,
  output logic             load_inputs,
  output logic             sel_mux_init,
  output logic             load_regs_iter,
  output logic             enab_add_sub,
  output logic [CNT_W-1:0] iter_count,
  output logic             invert_sign,
  output logic             load_result,
  output logic             ready_cordic,
  output logic             err_timeout
);

  // The wait counter only has to reach TMO-1: the TMO-th WAIT_ADD cycle is
  // the one in which the timeout is taken.
  localparam int WAIT_W = (TMO < 2) ? 1 : $clog2(TMO);

  cordic_state_e state_reg, state_next;

  logic       op_reg;
  logic [1:0] region_reg;
  logic       err_reg;

  logic              iter_term;
  logic [WAIT_W-1:0] wait_count;
  logic              wait_term;
  logic              timeout_hit;

  // Ready wins over a simultaneous timeout.
  assign timeout_hit = (state_reg == ST_WAIT_ADD) && !add_sub_ready && wait_term;

  // Micro-rotation index: cleared in INIT, advanced in UPDATE, saturates at
  // ITER-1 so it still shows the last index through SIGN_FIX and DONE.
  cordic_iter_counter #(
    .W    (CNT_W),
    .LAST (ITER - 1)
  ) u_iter_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (state_reg == ST_INIT),
    .load     (1'b0),
    .load_val ('0),
    .en       (state_reg == ST_UPDATE),
    .count    (iter_count),
    .term     (iter_term)
  );

  // Cycles spent in WAIT_ADD for the current add/sub request.
  cordic_iter_counter #(
    .W    (WAIT_W),
    .LAST (TMO - 1)
  ) u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (state_reg == ST_START_ADD),
    .load     (1'b0),
    .load_val ('0),
    .en       (state_reg == ST_WAIT_ADD),
    .count    (wait_count),
    .term     (wait_term)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Operation and quadrant are captured only on the start transition, so the
  // inputs are free to change for the rest of the run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_reg     <= OP_COS;
      region_reg <= REG_NONE0;
    end else if ((state_reg == ST_IDLE) && beg_fsm_cordic) begin
      op_reg     <= operation;
      region_reg <= shift_region_flag;
    end
  end

  // Sticky until the next INIT so it stays valid alongside ready_cordic.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_reg <= 1'b0;
    end else if (state_reg == ST_INIT) begin
      err_reg <= 1'b0;
    end else if (timeout_hit) begin
      err_reg <= 1'b1;
    end
  end

  assign err_timeout = err_reg;

  always_comb begin
    state_next     = state_reg;
    busy           = 1'b1;
    load_inputs    = 1'b0;
    sel_mux_init   = 1'b0;
    load_regs_iter = 1'b0;
    enab_add_sub   = 1'b0;
    load_result    = 1'b0;
    ready_cordic   = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        busy = 1'b0;
        if (beg_fsm_cordic) begin
          state_next = ST_LOAD_IN;
        end
      end
      ST_LOAD_IN: begin
        load_inputs = 1'b1;
        state_next  = ST_INIT;
      end
      ST_INIT: begin
        sel_mux_init   = 1'b1;
        load_regs_iter = 1'b1;
        state_next     = ST_START_ADD;
      end
      ST_START_ADD: begin
        enab_add_sub = 1'b1;
        state_next   = ST_WAIT_ADD;
      end
      ST_WAIT_ADD: begin
        if (add_sub_ready) begin
          state_next = ST_UPDATE;
        end else if (wait_term) begin
          state_next = ST_SIGN_FIX;
        end
      end
      ST_UPDATE: begin
        load_regs_iter = 1'b1;
        state_next     = iter_term ? ST_SIGN_FIX : ST_START_ADD;
      end
      ST_SIGN_FIX: begin
        load_result = 1'b1;
        state_next  = ST_DONE;
      end
      ST_DONE: begin
        ready_cordic = 1'b1;
        if (ack_cordic) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        busy       = 1'b0;
        state_next = ST_IDLE;
      end
    endcase

    // Forced low in IDLE even though the latched op/region persist there.
    invert_sign = busy && needs_invert(op_reg, region_reg);
  end

endmodule

// File: tb/tb_cordic_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cordic_seq_ctrl
// Self-checking bench for cordic_seq_ctrl (ITER=4, TMO=15). Each run is
// described by a list of add/sub latencies (0 = never ready); a reference
// model derives the expected completion edge, pulse counts, error flag and
// sign-correction bit from that list.
// -----------------------------------------------------------------------------
module tb_cordic_seq_ctrl;
  import cordic_pkg::*;

  localparam int ITER_T = 4;
  localparam int CNT_T  = 3;
  localparam int TMO_T  = 15;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             beg_fsm_cordic = 1'b0;
  logic             ack_cordic = 1'b0;
  logic             operation = 1'b0;
  logic [1:0]       shift_region_flag = 2'b00;
  logic             add_sub_ready = 1'b0;
  logic             busy;
  logic             load_inputs;
  logic             sel_mux_init;
  logic             load_regs_iter;
  logic             enab_add_sub;
  logic [CNT_T-1:0] iter_count;
  logic             invert_sign;
  logic             load_result;
  logic             ready_cordic;
  logic             err_timeout;

  int n_cmp = 0;
  int n_bad = 0;

  logic [CNT_T+8:0] all_outs;
  assign all_outs = {busy, load_inputs, sel_mux_init, load_regs_iter, enab_add_sub,
                     iter_count, invert_sign, load_result, ready_cordic, err_timeout};

  always #5 clk = ~clk;

  cordic_seq_ctrl #(
    .ITER  (ITER_T),
    .CNT_W (CNT_T),
    .TMO   (TMO_T)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .beg_fsm_cordic    (beg_fsm_cordic),
    .ack_cordic        (ack_cordic),
    .operation         (operation),
    .shift_region_flag (shift_region_flag),
    .add_sub_ready     (add_sub_ready),
    .busy              (busy),
    .load_inputs       (load_inputs),
    .sel_mux_init      (sel_mux_init),
    .load_regs_iter    (load_regs_iter),
    .enab_add_sub      (enab_add_sub),
    .iter_count        (iter_count),
    .invert_sign       (invert_sign),
    .load_result       (load_result),
    .ready_cordic      (ready_cordic),
    .err_timeout       (err_timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sign correction truth table indexed by {op, region}: only cos/01 and sin/10.
  function automatic logic ref_invert(input logic op, input logic [1:0] rg);
    logic [7:0] tab;
    tab = 8'b0100_0010;
    return tab[{op, rg}];
  endfunction

  // One complete operation. ks[i] is the number of WAIT_ADD cycles before
  // add/sub ready for micro-rotation i (0 = never). Edge 0 samples the start.
  task automatic run_op(input logic op, input logic [1:0] rg, input int ks[ITER_T],
                        input bit spurious, input bit beg_with_ack, input string tag);
    int   idx, exp_done, exp_iters, exp_lri;
    bit   exp_to;
    logic exp_inv;
    int   n_enab, n_li, n_lr, n_smi, n_lri, remaining, ready_at, hold;

    // Reference: 2 edges to reach START_ADD, then (2+k) per completed
    // rotation, or 1+TMO for the stalled one; one more edge into DONE.
    idx = 2; exp_iters = 0; exp_to = 1'b0;
    for (int i = 0; i < ITER_T; i++) begin
      exp_iters++;
      if (ks[i] == 0) begin
        idx += 1 + TMO_T;
        exp_to = 1'b1;
        break;
      end
      idx += 2 + ks[i];
    end
    exp_done = idx + 1;
    exp_lri  = 1 + (exp_to ? exp_iters - 1 : exp_iters);
    exp_inv  = ref_invert(op, rg);

    operation = op;
    shift_region_flag = rg;
    beg_fsm_cordic = 1'b1;
    tick();

    n_enab = 0; n_li = 0; n_lr = 0; n_smi = 0; n_lri = 0; remaining = 0; ready_at = -1;
    for (int n = 0; n <= exp_done + 5; n++) begin
      add_sub_ready = 1'b0;
      beg_fsm_cordic = 1'b0;
      if (remaining > 0) begin
        remaining--;
        if (remaining == 0) add_sub_ready = 1'b1;
      end

      n_cmp++;
      if (busy !== 1'b1) begin
        n_bad++;
        $display("FAIL %s busy edge %0d: got %b want 1", tag, n, busy);
      end
      n_cmp++;
      if (invert_sign !== exp_inv) begin
        n_bad++;
        $display("FAIL %s invert_sign edge %0d: got %b want %b", tag, n, invert_sign, exp_inv);
      end
      if (load_inputs) n_li++;
      if (load_result) n_lr++;
      if (sel_mux_init) n_smi++;
      if (load_regs_iter) n_lri++;
      if (enab_add_sub) begin
        n_cmp++;
        if (iter_count !== CNT_T'(n_enab)) begin
          n_bad++;
          $display("FAIL %s iter_count at enab %0d: got %0d want %0d", tag, n_enab, iter_count, n_enab);
        end
        remaining = (n_enab < ITER_T) ? ks[n_enab] : 0;
        n_enab++;
        if (spurious) add_sub_ready = 1'b1;
      end
      if (ready_cordic) begin
        ready_at = n;
        break;
      end
      if (spurious) begin
        if (load_regs_iter && !sel_mux_init) add_sub_ready = 1'b1;
        beg_fsm_cordic = ($urandom_range(0, 2) == 0);
        operation = 1'($urandom);
        shift_region_flag = 2'($urandom);
      end
      tick();
    end
    add_sub_ready = 1'b0;
    beg_fsm_cordic = 1'b0;

    n_cmp++;
    if (ready_at != exp_done) begin
      n_bad++;
      $display("FAIL %s ready edge: got %0d want %0d (-1 = never)", tag, ready_at, exp_done);
    end
    n_cmp++;
    if (n_enab != exp_iters) begin
      n_bad++;
      $display("FAIL %s enab pulses: got %0d want %0d", tag, n_enab, exp_iters);
    end
    n_cmp++;
    if ((n_li != 1) || (n_lr != 1) || (n_smi != 1) || (n_lri != exp_lri)) begin
      n_bad++;
      $display("FAIL %s pulse counts li/lr/smi/lri: got %0d/%0d/%0d/%0d want 1/1/1/%0d",
               tag, n_li, n_lr, n_smi, n_lri, exp_lri);
    end
    n_cmp++;
    if (err_timeout !== exp_to) begin
      n_bad++;
      $display("FAIL %s err_timeout: got %b want %b", tag, err_timeout, exp_to);
    end
    if (ready_at < 0) return;

    hold = $urandom_range(0, 3);
    for (int h = 0; h < hold; h++) begin
      tick();
      n_cmp++;
      if ((ready_cordic !== 1'b1) || (err_timeout !== exp_to)) begin
        n_bad++;
        $display("FAIL %s hold ready/err: got %b/%b want 1/%b", tag, ready_cordic, err_timeout, exp_to);
      end
    end

    ack_cordic = 1'b1;
    beg_fsm_cordic = beg_with_ack;
    tick();
    ack_cordic = 1'b0;
    beg_fsm_cordic = 1'b0;
    n_cmp++;
    if ((busy !== 1'b0) || (ready_cordic !== 1'b0) || (invert_sign !== 1'b0)) begin
      n_bad++;
      $display("FAIL %s after ack busy/ready/inv: got %b/%b/%b want 0/0/0",
               tag, busy, ready_cordic, invert_sign);
    end
    tick();
    n_cmp++;
    if ((busy !== 1'b0) || (load_inputs !== 1'b0)) begin
      n_bad++;
      $display("FAIL %s idle after ack busy/load_inputs: got %b/%b want 0/0", tag, busy, load_inputs);
    end
    $display("run %s op=%0d rg=%0d ks=%0d,%0d,%0d,%0d ready_edge=%0d err=%b",
             tag, op, rg, ks[0], ks[1], ks[2], ks[3], ready_at, err_timeout);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    n_cmp++;
    if (all_outs !== '0) begin
      n_bad++;
      $display("FAIL reset_asserted outputs: got %h want 0", all_outs);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if (all_outs !== '0) begin
        n_bad++;
        $display("FAIL reset_idle cycle %0d outputs: got %h want 0", i, all_outs);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    int ks[ITER_T];
    ks = '{1, 1, 1, 1};
    run_op(OP_COS, REG_INV_COS, ks, 1'b0, 1'b0, "basic_k1");
  endtask

  task automatic test_invert_table();
    int ks[ITER_T];
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < ITER_T; i++) ks[i] = $urandom_range(1, 3);
      run_op(c[2], c[1:0], ks, 1'b0, 1'b0, "invert");
    end
  endtask

  task automatic test_random_spurious();
    int ks[ITER_T];
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < ITER_T; i++) ks[i] = $urandom_range(1, 4);
      run_op(1'($urandom), 2'($urandom), ks, 1'b1, 1'($urandom), "random");
    end
  endtask

  task automatic test_timeout();
    int ks[ITER_T];
    ks = '{0, 1, 1, 1};
    run_op(OP_SIN, REG_INV_SIN, ks, 1'b0, 1'b0, "timeout_it0");
    ks = '{3, 2, 0, 1};
    run_op(OP_COS, REG_NONE3, ks, 1'b1, 1'b0, "timeout_it2");
    ks = '{2, 1, 2, 1};
    run_op(OP_COS, REG_NONE0, ks, 1'b0, 1'b0, "after_timeout");
  endtask

  task automatic test_back_to_back();
    int ks[ITER_T];
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < ITER_T; i++) ks[i] = $urandom_range(1, 2);
      run_op(OP_SIN, REG_INV_SIN, ks, 1'b0, 1'b1, "back_to_back");
    end
  endtask

  task automatic test_async_reset();
    bool_wait: begin end
    operation = OP_COS;
    shift_region_flag = REG_INV_COS;
    beg_fsm_cordic = 1'b1;
    tick();
    beg_fsm_cordic = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 60 && !seen; n++) begin
        add_sub_ready = 1'b1;  // ready whenever waited on: k = 1
        if (enab_add_sub && (iter_count == CNT_T'(2))) seen = 1'b1;
        else tick();
      end
      n_cmp++;
      if (!seen) begin
        n_bad++;
        $display("FAIL async_reset never reached iteration 2: got iter_count %0d want 2", iter_count);
      end
    end
    add_sub_ready = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (all_outs !== '0) begin
      n_bad++;
      $display("FAIL async_reset immediate outputs: got %h want 0", all_outs);
    end
    tick();
    tick();
    rst = 1'b1;
    add_sub_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++;
      if (all_outs !== '0) begin
        n_bad++;
        $display("FAIL async_reset recovery cycle %0d outputs: got %h want 0", i, all_outs);
      end
    end
    add_sub_ready = 1'b0;
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_invert_table();
    test_random_spurious();
    test_timeout();
    test_back_to_back();
    test_async_reset();
    test_basic();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cordic_seq_ctrl.md
# cordic_seq_ctrl

Sequencing FSM for the CORDIC Arch2 sine/cosine datapath. Accepts a start request with operation and quadrant flag. Drives input and iteration register loads and the floating-point add/sub handshake for a fixed number of micro-rotations. Flags final quadrant sign correction and presents the result with a ready/ack handshake to the FPU interface.

## Interface
Parameters:
- ITER, 24, number of CORDIC micro-rotations per operation (≥1)
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > ITER
- TMO, 15, max cycles spent in WAIT_ADD before timeout (≥1)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- beg_fsm_cordic  in  1  start request, sampled in IDLE only
- ack_cordic  in  1  consumer acknowledge, sampled in DONE only
- operation  in  1  0 = cosine, 1 = sine
- shift_region_flag  in  2  quadrant code from range reduction
- add_sub_ready  in  1  FP add/sub result valid
- busy  out  1  high in every state except IDLE
- load_inputs  out  1  one-cycle pulse: capture angle into input registers
- sel_mux_init  out  1  1 = iteration regs take initial values, 0 = feedback
- load_regs_iter  out  1  one-cycle pulse: capture X/Y/Z iteration results
- enab_add_sub  out  1  one-cycle pulse: start FP add/sub
- iter_count  out  CNT_W  current iteration index, 0..ITER-1
- invert_sign  out  1  sign-inverter control, from latched op/region
- load_result  out  1  one-cycle pulse: capture sign-corrected result
- ready_cordic  out  1  result valid, held until ack
- err_timeout  out  1  set if add/sub stalled beyond TMO; valid with ready_cordic

## Operation
- States: IDLE, LOAD_IN, INIT, START_ADD, WAIT_ADD, UPDATE, SIGN_FIX, DONE.
- IDLE → LOAD_IN when beg_fsm_cordic=1. operation and shift_region_flag are latched on this transition. Later input changes are ignored until the next IDLE.
- LOAD_IN: load_inputs=1; → INIT.
- INIT: sel_mux_init=1, load_regs_iter=1, iter_count cleared to 0, err_timeout cleared; → START_ADD.
- START_ADD: enab_add_sub=1, wait counter cleared; → WAIT_ADD.
- WAIT_ADD: add_sub_ready=1 → UPDATE. Wait counter reaching TMO with no ready sets err_timeout and → SIGN_FIX.
- UPDATE: load_regs_iter=1, sel_mux_init=0. If iter_count==ITER-1 → SIGN_FIX, otherwise iter_count+1 and → START_ADD.
- SIGN_FIX: load_result=1; → DONE.
- DONE: ready_cordic=1; ack_cordic=1 → IDLE.
- invert_sign = (op==0 && region==2'b01) || (op==1 && region==2'b10), using latched values. All other codes, including 00 and 11, give 0. Held stable from LOAD_IN through DONE; 0 in IDLE.
- add_sub_ready outside WAIT_ADD is ignored. beg_fsm_cordic outside IDLE is ignored.
- Simultaneous beg_fsm_cordic and ack_cordic in DONE → IDLE. A new start needs beg_fsm_cordic high in IDLE.
- Counter arithmetic is unsigned, with no wrap: the counter never exceeds ITER-1.

## Timing
- Reset (async, rst=0): state IDLE. All outputs 0, iter_count=0, err_timeout=0, latched op/region=0.
- Reset mid-operation aborts immediately; no result is produced.
- All outputs are registered-state Moore decodes; no combinational input→output paths.
- With add_sub_ready after k cycles in WAIT_ADD (k≥1), beg_fsm_cordic sampled at edge 0 gives ready_cordic high after 3 + ITER·(2+k) + 1 edges.
- For k=1, ITER=24: 76 cycles.
- Timeout path: err_timeout is asserted after TMO cycles in WAIT_ADD, then SIGN_FIX, then DONE. It stays set until the next INIT.

## Structure
- Shared package cordic_pkg holds:
  - state encoding enum (3 bits)
  - operation constants OP_COS=0, OP_SIN=1
  - region codes REG_NONE0=2'b00, REG_INV_COS=2'b01, REG_INV_SIN=2'b10, REG_NONE3=2'b11
- One natural sub-module: cordic_iter_counter. It is a loadable up-counter with clear, enable and terminal flag (count==ITER-1), reused for the TMO wait counter with a second instance.
- The FSM next-state logic and output decode stay in this module.

## Test plan
- Reset released, no stimulus → all outputs 0, state IDLE for 10 cycles.
- ITER=4, op=0, region=01, add_sub_ready one cycle after each enab_add_sub:
  - invert_sign=1 from LOAD_IN.
  - Exactly 4 enab_add_sub pulses; iter_count 0,1,2,3.
  - ready_cordic at cycle 3+4·3+1=16.
  - Held until ack_cordic, then IDLE.
- op=1, region=10 → invert_sign=1. op=1, region=01 and op=0, region=11 → invert_sign=0.
- Region input toggled mid-run → invert_sign unchanged.
- add_sub_ready never asserted, TMO=15 → err_timeout=1, load_result pulse, ready_cordic after 15 WAIT_ADD cycles. Next run clears err_timeout in INIT.
- Async reset at iteration 2 → outputs 0 immediately. Spurious add_sub_ready and beg_fsm_cordic pulses during WAIT_ADD/UPDATE cause no extra iterations or restart.
